pc_sequencer: RTL and testbench



---
 rtl/pc_seq_if.sv | 28 ++
 rtl/pc_sequencer.sv | 100 ++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// Decoder-to-sequencer control bundle plus the fetch address and stack status
// that flow back towards the program memory and decoder.
interface pc_seq_if #(
   parameter int PC_WIDTH  = 8,
   parameter int CNT_WIDTH = 3
);
   logic                 stall;
   logic                 jump_en;
   logic                 call_en;
   logic                 ret_en;
   logic                 branch_en;
   logic [PC_WIDTH-1:0]  jump_addr;
   logic [PC_WIDTH-1:0]  branch_off;
   logic [PC_WIDTH-1:0]  pc;
   logic [CNT_WIDTH-1:0] stack_cnt;
   logic                 ovf_err;
   logic                 unf_err;

   modport master (
      output stall, jump_en, call_en, ret_en, branch_en, jump_addr, branch_off,
      input  pc, stack_cnt, ovf_err, unf_err
   );

   modport slave (
      input  stall, jump_en, call_en, ret_en, branch_en, jump_addr, branch_off,
      output pc, stack_cnt, ovf_err, unf_err
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with jump, call/return via a hardware return stack, and sticky
// stack misuse flags. Define PC_SEQ_BRANCH_REL_EN to enable pc-relative branches.
module pc_sequencer #(
   parameter int PC_WIDTH    = 8,
   parameter int STACK_DEPTH = 4,
   parameter int CNT_WIDTH   = 3
) (
   input  logic     clk,
   input  logic     res,
   pc_seq_if.slave  bus
);
   localparam int IDX_W = $clog2(STACK_DEPTH);

   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;
   logic                 push_en;
   logic [PC_WIDTH-1:0]  pc_inc;
   logic [IDX_W-1:0]     push_idx;
   logic [IDX_W-1:0]     top_idx;
   logic                 stack_full;
   logic                 stack_empty;
   logic [PC_WIDTH-1:0]  stack_q [STACK_DEPTH];

   assign pc_inc      = pc_q + PC_WIDTH'(1);
   assign push_idx    = IDX_W'(cnt_q);
   assign top_idx     = IDX_W'(cnt_q - CNT_WIDTH'(1));
   assign stack_full  = (cnt_q == CNT_WIDTH'(STACK_DEPTH));
   assign stack_empty = (cnt_q == '0);

`ifndef PC_SEQ_BRANCH_REL_EN
   logic unused_branch;
   assign unused_branch = ^{bus.branch_en, bus.branch_off};
`endif

   // Strict priority chain: stall, ret, call, branch, jump, increment.
   always_comb begin
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (bus.stall) begin
         pc_d = pc_q;
      end else if (bus.ret_en) begin
         if (stack_empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
         end else begin
            pc_d  = stack_q[top_idx];
            cnt_d = cnt_q - CNT_WIDTH'(1);
         end
      end else if (bus.call_en) begin
         if (stack_full) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
         end else begin
            push_en = 1'b1;
            pc_d    = bus.jump_addr;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
         end
`ifdef PC_SEQ_BRANCH_REL_EN
      end else if (bus.branch_en) begin
         // Same-width add is the sign-extended add modulo 2^PC_WIDTH.
         pc_d = pc_q + bus.branch_off;
`endif
      end else if (bus.jump_en) begin
         pc_d = bus.jump_addr;
      end else begin
         pc_d = pc_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         pc_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack contents need no reset; only entries below stack_cnt are ever read.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= pc_inc;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.stack_cnt = cnt_q;
   assign bus.ovf_err   = ovf_q;
   assign bus.unf_err   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue-based reference model compared every
// cycle, plus hand-computed checkpoints from the planned scenarios.
module tb_pc_sequencer;
   localparam int PC_W  = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;
`ifdef PC_SEQ_BRANCH_REL_EN
   localparam bit BRANCH = 1'b1;
`else
   localparam bit BRANCH = 1'b0;
`endif

   logic clk;
   logic res;
   int   checks;
   int   failures;

   pc_seq_if #(.PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W)) bus ();

   pc_sequencer #(.PC_WIDTH(PC_W), .STACK_DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
      .clk (clk),
      .res (res),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: stack as a queue, pc as an integer modulo 256.
   int unsigned m_pc;
   int unsigned m_stack[$];
   bit          m_ovf;
   bit          m_unf;
   bit          m_valid;

   initial begin
      m_valid = 1'b0;
      m_pc    = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   end

   always @(posedge clk) begin
      if (res) begin
         m_pc = 0;
         m_stack.delete();
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid && !bus.stall) begin
         if (bus.ret_en) begin
            if (m_stack.size() == 0) begin
               m_pc  = (m_pc + 1) % 256;
               m_unf = 1'b1;
            end else begin
               m_pc = m_stack.pop_back();
            end
         end else if (bus.call_en) begin
            if (m_stack.size() == DEPTH) begin
               m_pc  = (m_pc + 1) % 256;
               m_ovf = 1'b1;
            end else begin
               m_stack.push_back((m_pc + 1) % 256);
               m_pc = int'(bus.jump_addr);
            end
         end else if (bus.branch_en && BRANCH) begin
            m_pc = (m_pc + int'(bus.branch_off)) % 256;
         end else if (bus.jump_en) begin
            m_pc = int'(bus.jump_addr);
         end else begin
            m_pc = (m_pc + 1) % 256;
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         checks++;
         if (bus.pc !== PC_W'(m_pc) || bus.stack_cnt !== CNT_W'(m_stack.size()) ||
             bus.ovf_err !== m_ovf || bus.unf_err !== m_unf) begin
            failures++;
            $display("FAIL model_cmp t=%0t got pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                     $time, bus.pc, bus.stack_cnt, bus.ovf_err, bus.unf_err,
                     m_pc[7:0], m_stack.size(), m_ovf, m_unf);
         end
      end
   end

   task automatic cyc(input logic r, input logic st, input logic je, input logic ce,
                      input logic re, input logic be, input logic [7:0] ja, input logic [7:0] bo);
      res           = r;
      bus.stall     = st;
      bus.jump_en   = je;
      bus.call_en   = ce;
      bus.ret_en    = re;
      bus.branch_en = be;
      bus.jump_addr = ja;
      bus.branch_off = bo;
      @(negedge clk);
      $display("txn t=%0t res=%b st=%b j=%b c=%b r=%b b=%b ja=%h bo=%h -> pc=%h cnt=%0d ovf=%b unf=%b",
               $time, r, st, je, ce, re, be, ja, bo, bus.pc, bus.stack_cnt, bus.ovf_err, bus.unf_err);
   endtask

   task automatic idle();      cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00); endtask
   task automatic jump(input logic [7:0] a); cyc(0, 0, 1, 0, 0, 0, a, 8'h00); endtask
   task automatic call(input logic [7:0] a); cyc(0, 0, 0, 1, 0, 0, a, 8'h00); endtask
   task automatic ret();       cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00); endtask

   task automatic expect_state(input string name, input logic [7:0] pc_e, input int cnt_e,
                               input logic ovf_e, input logic unf_e);
      checks++;
      if (bus.pc !== pc_e || bus.stack_cnt !== CNT_W'(cnt_e) ||
          bus.ovf_err !== ovf_e || bus.unf_err !== unf_e) begin
         failures++;
         $display("FAIL %s got pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                  name, bus.pc, bus.stack_cnt, bus.ovf_err, bus.unf_err, pc_e, cnt_e, ovf_e, unf_e);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      // Reset, then free-run
      cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      expect_state("reset1", 8'h00, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      expect_state("reset2", 8'h00, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         idle();
         expect_state("free_run", 8'(i), 0, 0, 0);
      end
      jump(8'hFF);
      idle();
      expect_state("wrap_255", 8'h00, 0, 0, 0);

      // Jump and stall
      jump(8'h05);
      jump(8'h14);
      expect_state("jump_14", 8'h14, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 0, 0, 0, 8'h30, 8'h00);
         expect_state("stall_hold", 8'h14, 0, 0, 0);
      end
      idle();
      expect_state("after_stall", 8'h15, 0, 0, 0);

      // Nested calls and returns
      jump(8'h03);
      call(8'h20);
      expect_state("call_20", 8'h20, 1, 0, 0);
      idle();
      call(8'h40);
      expect_state("call_40", 8'h40, 2, 0, 0);
      ret();
      expect_state("ret_22", 8'h22, 1, 0, 0);
      ret();
      expect_state("ret_04", 8'h04, 0, 0, 0);

      // Overflow then underflow
      call(8'h10);
      call(8'h20);
      call(8'h30);
      call(8'h50);
      expect_state("stack_full", 8'h50, 4, 0, 0);
      call(8'h70);
      expect_state("overflow", 8'h51, 4, 1, 0);
      ret();
      expect_state("pop_31", 8'h31, 3, 1, 0);
      ret();
      ret();
      ret();
      expect_state("pop_05", 8'h05, 0, 1, 0);
      ret();
      expect_state("underflow", 8'h06, 0, 1, 1);
      idle();
      idle();
      expect_state("sticky", 8'h08, 0, 1, 1);

      // Stall blocks a return; call+ret together pops
      call(8'h90);
      cyc(0, 1, 0, 0, 1, 0, 8'h00, 8'h00);
      expect_state("stall_ret", 8'h90, 1, 1, 1);
      cyc(0, 0, 0, 1, 1, 0, 8'hA0, 8'h00);
      expect_state("call_ret_prio", 8'h09, 0, 1, 1);

      // Reset overrides a concurrent call
      cyc(1, 0, 0, 1, 0, 0, 8'h77, 8'h00);
      expect_state("reset_call", 8'h00, 0, 0, 0);

      // Relative branch (or fall-through when the feature is absent)
      jump(8'h10);
      cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'hFC);
      expect_state("branch_back", BRANCH ? 8'h0C : 8'h11, 0, 0, 0);
      jump(8'hFE);
      cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'h05);
      expect_state("branch_wrap", BRANCH ? 8'h03 : 8'hFF, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 1, 8'h40, 8'h02);
      expect_state("branch_vs_jump", BRANCH ? (BRANCH ? 8'h05 : 8'h00) : 8'h40, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
